// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: round-robin owner of the single framebuffer write port.
// Each writer engine requests the port, keeps it until it pulses done (or
// drops req), and the port then spends one dead RELEASE cycle before the
// next owner is granted. Requester data reaches the mem_* outputs one
// cycle after it is presented while granted.
// Optional feature macro: FB_ARB_WATCHDOG_EN builds a hold-time watchdog
// that forcibly releases an owner after HOLD_MAX grant cycles and raises a
// sticky watchdog_err.
module fb_write_arbiter #(
  parameter int NREQ     = 3,
  parameter int ID_W     = 2,
  parameter int HOLD_MAX = 65536
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    done,
  input  logic [NREQ*19-1:0] req_waddr,
  input  logic [NREQ*3-1:0]  req_wdata,
  input  logic [NREQ-1:0]    req_wenable,
  output logic [NREQ-1:0]    gnt,
  output logic [ID_W-1:0]    active_id,
  output logic               busy,
  output logic [18:0]        mem_waddr,
  output logic [2:0]         mem_wdata,
  output logic               mem_wenable,
  output logic               watchdog_err
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t          state;
  logic [ID_W-1:0] last_id;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] sel;
  logic            found;
  logic            any_req;
  logic            cur_req;
  logic            cur_done;
  logic            cur_wen;
  logic [18:0]     cur_waddr;
  logic [2:0]      cur_wdata;
  logic            wd_expire;
  logic            release_now;

  // Round-robin pick: first requesting index after last_id, wrapping at NREQ.
  always_comb begin
    sel     = '0;
    found   = 1'b0;
    any_req = |req;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] &&
            ((int'(last_id) + k == i) || (int'(last_id) + k == i + NREQ))) begin
          sel   = ID_W'(i);
          found = 1'b1;
        end
      end
    end
  end

  // Select the current owner's request, release pulse and write data.
  always_comb begin
    cur_req   = 1'b0;
    cur_done  = 1'b0;
    cur_wen   = 1'b0;
    cur_waddr = '0;
    cur_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == ID_W'(i)) begin
        cur_req   = req[i];
        cur_done  = done[i];
        cur_wen   = req_wenable[i];
        cur_waddr = req_waddr[i*19 +: 19];
        cur_wdata = req_wdata[i*3 +: 3];
      end
    end
  end

`ifdef FB_ARB_WATCHDOG_EN
  logic [31:0] hold_cnt;

  assign wd_expire = (hold_cnt == 32'(HOLD_MAX - 1));

  // Count grant cycles of the current owner; zero outside GRANT so each
  // ownership starts from 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) hold_cnt <= '0;
    else if (state == GRANT) hold_cnt <= hold_cnt + 32'd1;
    else hold_cnt <= '0;
  end

  // Latch a watchdog error when an owner is forcibly released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) watchdog_err <= 1'b0;
    else if (state == GRANT && wd_expire) watchdog_err <= 1'b1;
  end
`else
  assign wd_expire = 1'b0;
  // Without the watchdog HOLD_MAX has no effect and the flag is constant 0.
  assign watchdog_err = (HOLD_MAX < 0);
`endif

  assign release_now = cur_done | ~cur_req | wd_expire;

  // Arbiter FSM with registered grant, status and memory write outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_id     <= ID_W'(NREQ - 1);
      winner      <= '0;
      gnt         <= '0;
      active_id   <= '0;
      busy        <= 1'b0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      mem_wenable <= 1'b0;
    end else begin
      case (state)
        IDLE, RELEASE: begin
          mem_wenable <= 1'b0;
          gnt         <= '0;
          active_id   <= '0;
          if (any_req) begin
            state     <= GRANT;
            winner    <= sel;
            gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << sel;
            active_id <= sel;
            busy      <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          mem_waddr   <= cur_waddr;
          mem_wdata   <= cur_wdata;
          mem_wenable <= cur_wen;
          if (release_now) begin
            state     <= RELEASE;
            gnt       <= '0;
            active_id <= '0;
            last_id   <= winner;
          end
        end
        default: begin
          state       <= IDLE;
          gnt         <= '0;
          active_id   <= '0;
          busy        <= 1'b0;
          mem_wenable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: directed scenarios for the framebuffer write arbiter
// with three requesters and a short watchdog limit of 16 grant cycles.
module tb_fb_write_arbiter;

  localparam int NREQ = 3;
  localparam int ID_W = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   done = '0;
  logic [NREQ*19-1:0] req_waddr = '0;
  logic [NREQ*3-1:0] req_wdata = '0;
  logic [NREQ-1:0]   req_wenable = '0;
  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   active_id;
  logic              busy;
  logic [18:0]       mem_waddr;
  logic [2:0]        mem_wdata;
  logic              mem_wenable;
  logic              watchdog_err;

  int passed = 0;
  int total  = 0;

  fb_write_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .HOLD_MAX(16)) dut (
    .clock(clock), .reset(reset), .req(req), .done(done),
    .req_waddr(req_waddr), .req_wdata(req_wdata), .req_wenable(req_wenable),
    .gnt(gnt), .active_id(active_id), .busy(busy),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wenable(mem_wenable),
    .watchdog_err(watchdog_err)
  );

  always #5 clock = ~clock;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    req = '0; done = '0; req_wenable = '0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    total++; if ({gnt, active_id, busy} !== 6'b0) $display("[TB] FAIL reset_grant: got gnt=%b id=%0d busy=%b want 0", gnt, active_id, busy); else passed++;
    total++; if ({mem_waddr, mem_wdata, mem_wenable} !== 23'b0) $display("[TB] FAIL reset_mem: got %h/%h/%b want 0", mem_waddr, mem_wdata, mem_wenable); else passed++;
    total++; if (watchdog_err !== 1'b0) $display("[TB] FAIL reset_wd: got %b want 0", watchdog_err); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_basic_write();
    logic [18:0] ea;
    req = 3'b001;
    tick();
    total++; if (gnt !== 3'b001 || active_id !== 2'd0 || busy !== 1'b1) $display("[TB] FAIL basic_grant: got gnt=%b id=%0d busy=%b want 001/0/1", gnt, active_id, busy); else passed++;
    for (int k = 0; k < 4; k++) begin
      ea = 19'h00100 + 19'(k);
      req_waddr[0 +: 19] = ea;
      req_wdata[0 +: 3] = 3'b101;
      req_wenable[0] = 1'b1;
      done = (k == 3) ? 3'b001 : 3'b000;
      tick();
      total++; if (mem_waddr !== ea || mem_wdata !== 3'b101 || mem_wenable !== 1'b1) $display("[TB] FAIL basic_mem%0d: got %h/%b/%b want %h/101/1", k, mem_waddr, mem_wdata, mem_wenable, ea); else passed++;
      total++; if (gnt !== ((k == 3) ? 3'b000 : 3'b001)) $display("[TB] FAIL basic_gnt%0d: got %b", k, gnt); else passed++;
    end
    done = '0; req_wenable = '0; req = '0;
    tick();
    total++; if (mem_wenable !== 1'b0 || gnt !== 3'b000 || busy !== 1'b0) $display("[TB] FAIL basic_after: got wen=%b gnt=%b busy=%b want 0/000/0", mem_wenable, gnt, busy); else passed++;
  endtask

  task automatic test_round_robin();
    int order [4] = '{0, 1, 2, 0};
    logic [NREQ-1:0] eg;
    do_reset();
    req = 3'b111;
    tick();
    for (int n = 0; n < 4; n++) begin
      eg = 3'b001 << order[n];
      total++; if (gnt !== eg || active_id !== ID_W'(order[n])) $display("[TB] FAIL rr_grant%0d: got gnt=%b id=%0d want %b/%0d", n, gnt, active_id, eg, order[n]); else passed++;
      tick();
      total++; if (gnt !== eg) $display("[TB] FAIL rr_hold%0d: got %b want %b", n, gnt, eg); else passed++;
      done = eg;
      tick();
      total++; if (gnt !== 3'b000 || active_id !== 2'd0 || busy !== 1'b1) $display("[TB] FAIL rr_dead%0d: got gnt=%b id=%0d busy=%b want 000/0/1", n, gnt, active_id, busy); else passed++;
      done = '0;
      if (n == 3) req = '0;
      tick();
    end
    total++; if (gnt !== 3'b000 || busy !== 1'b0) $display("[TB] FAIL rr_idle: got gnt=%b busy=%b want 000/0", gnt, busy); else passed++;
  endtask

  task automatic test_ignore_other();
    do_reset();
    req = 3'b001;
    tick();
    req = 3'b011;
    req_waddr[0 +: 19] = 19'h1A2B3; req_wdata[0 +: 3] = 3'd3; req_wenable[0] = 1'b1;
    req_waddr[19 +: 19] = 19'h05555; req_wdata[3 +: 3] = 3'd6; req_wenable[1] = 1'b1;
    done = 3'b010;
    tick();
    total++; if (gnt !== 3'b001 || mem_waddr !== 19'h1A2B3 || mem_wdata !== 3'd3) $display("[TB] FAIL ignore_data: got gnt=%b %h/%0d want 001 1a2b3/3", gnt, mem_waddr, mem_wdata); else passed++;
    req_wenable[0] = 1'b0;
    tick();
    total++; if (gnt !== 3'b001 || mem_wenable !== 1'b0) $display("[TB] FAIL ignore_wen: got gnt=%b wen=%b want 001/0", gnt, mem_wenable); else passed++;
    done = 3'b001; req_wenable = '0;
    tick();
    total++; if (gnt !== 3'b000) $display("[TB] FAIL ignore_rel: got %b want 000", gnt); else passed++;
    done = '0; req = 3'b010;
    tick();
    total++; if (gnt !== 3'b010 || active_id !== 2'd1) $display("[TB] FAIL ignore_next: got gnt=%b id=%0d want 010/1", gnt, active_id); else passed++;
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 3'b100;
    tick();
    total++; if (gnt !== 3'b100 || active_id !== 2'd2) $display("[TB] FAIL midrst_grant: got gnt=%b id=%0d want 100/2", gnt, active_id); else passed++;
    req_waddr[38 +: 19] = 19'h7FFFF; req_wdata[6 +: 3] = 3'd7; req_wenable[2] = 1'b1;
    tick();
    total++; if (mem_wenable !== 1'b1 || mem_waddr !== 19'h7FFFF) $display("[TB] FAIL midrst_write: got wen=%b addr=%h want 1/7ffff", mem_wenable, mem_waddr); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (gnt !== 3'b000 || mem_wenable !== 1'b0 || busy !== 1'b0 || mem_waddr !== 19'h0) $display("[TB] FAIL midrst_clear: got gnt=%b wen=%b busy=%b addr=%h want 0", gnt, mem_wenable, busy, mem_waddr); else passed++;
    tick();
    reset = 1'b0; req_wenable = '0; req = 3'b101;
    tick();
    total++; if (gnt !== 3'b001 || active_id !== 2'd0) $display("[TB] FAIL midrst_first: got gnt=%b id=%0d want 001/0", gnt, active_id); else passed++;
  endtask

  task automatic test_req_drop();
    done = 3'b001;
    tick();
    done = '0; req = 3'b100;
    tick();
    total++; if (gnt !== 3'b100 || active_id !== 2'd2) $display("[TB] FAIL drop_grant: got gnt=%b id=%0d want 100/2", gnt, active_id); else passed++;
    req = 3'b001;
    tick();
    total++; if (gnt !== 3'b000 || busy !== 1'b1) $display("[TB] FAIL drop_release: got gnt=%b busy=%b want 000/1", gnt, busy); else passed++;
    tick();
    total++; if (gnt !== 3'b001 || mem_wenable !== 1'b0) $display("[TB] FAIL drop_next: got gnt=%b wen=%b want 001/0", gnt, mem_wenable); else passed++;
    req = '0;
    tick();
    tick();
    total++; if (busy !== 1'b0 || gnt !== 3'b000) $display("[TB] FAIL drop_idle: got busy=%b gnt=%b want 0/000", busy, gnt); else passed++;
  endtask

  task automatic test_watchdog();
    int held;
    do_reset();
`ifdef FB_ARB_WATCHDOG_EN
    req = 3'b011;
    tick();
    held = (gnt === 3'b001) ? 1 : 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (gnt === 3'b001) held++;
    end
    total++; if (held !== 16) $display("[TB] FAIL wd_hold: got %0d grant cycles want 16", held); else passed++;
    tick();
    total++; if (gnt !== 3'b000 || watchdog_err !== 1'b1) $display("[TB] FAIL wd_expire: got gnt=%b err=%b want 000/1", gnt, watchdog_err); else passed++;
    tick();
    total++; if (gnt !== 3'b010 || watchdog_err !== 1'b1) $display("[TB] FAIL wd_next: got gnt=%b err=%b want 010/1", gnt, watchdog_err); else passed++;
    req = '0;
    tick();
    tick();
    total++; if (watchdog_err !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL wd_sticky: got err=%b busy=%b want 1/0", watchdog_err, busy); else passed++;
`else
    req = 3'b011;
    held = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (gnt === 3'b001) held++;
    end
    total++; if (held !== 40 || watchdog_err !== 1'b0) $display("[TB] FAIL nowd_hold: got %0d cycles err=%b want 40/0", held, watchdog_err); else passed++;
    req = '0;
    tick();
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_round_robin();
    test_ignore_other();
    test_reset_mid_grant();
    test_req_drop();
    test_watchdog();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
